mux4a1_bus_param: RTL and testbench

Parameterized 4-to-1 bus multiplexer with a combinational data path and a registered copy of the selected bus. It selects one of four `ANCHO`-bit data buses with a 2-bit select. The combinational output serves datapath users that need zero latency. The registered outputs serve users that need a clean, flop-launched bus with a known reset value.

---
 rtl/mux4a1_bus_param.sv | 60 ++++++
 tb/tb_mux4a1_bus_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux4a1_bus_param.sv
// Parameterized 4-to-1 bus mux: combinational selected bus plus a registered copy,
// registered select and change pulse. Optional parity output under MUX4A1_BUS_PARAM_PARITY_EN.
module mux4a1_bus_param #(
  parameter int ANCHO = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       S,
  input  logic [ANCHO-1:0] D0,
  input  logic [ANCHO-1:0] D1,
  input  logic [ANCHO-1:0] D2,
  input  logic [ANCHO-1:0] D3,
  output logic [ANCHO-1:0] Q,
  output logic [ANCHO-1:0] Q_r,
  output logic [1:0]       S_r,
`ifdef MUX4A1_BUS_PARAM_PARITY_EN
  output logic             CHG,
  output logic             PAR
`else
  output logic             CHG
`endif
);

`ifdef MUX4A1_BUS_PARAM_PARITY_EN
  function automatic logic even_par(input logic [ANCHO-1:0] v);
    return ^v;
  endfunction
`endif

  // Stage p0: combinational select; unknown select encodings fall back to D0
  always_comb begin
    case (S)
      2'd1:    Q = D1;
      2'd2:    Q = D2;
      2'd3:    Q = D3;
      default: Q = D0;
    endcase
  end

  // Stage p1: flop-launched copy of the selected bus; CHG compares against the held value
  always_ff @(posedge clk) begin
    if (rst) begin
      Q_r <= '0;
      S_r <= 2'd0;
      CHG <= 1'b0;
    end else begin
      Q_r <= Q;
      S_r <= S;
      CHG <= (Q != Q_r);
    end
  end

`ifdef MUX4A1_BUS_PARAM_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) PAR <= 1'b0;
    else     PAR <= even_par(Q);
  end
`endif

endmodule

// File: tb/tb_mux4a1_bus_param.sv
// Randomized self-checking bench for mux4a1_bus_param at ANCHO = 4, 8 and 16,
// compared against an array-indexed reference model. Parity checked when MUX4A1_BUS_PARAM_PARITY_EN is set.
module tb_mux4a1_bus_param;
  logic        clk;
  logic        rst;
  logic [1:0]  s;
  logic [3:0]  d4  [4];
  logic [7:0]  d8  [4];
  logic [15:0] d16 [4];

  logic [3:0]  q4,  qr4;
  logic [7:0]  q8,  qr8;
  logic [15:0] q16, qr16;
  logic [1:0]  sr4, sr8, sr16;
  logic        chg4, chg8, chg16;
  logic        par4, par8, par16;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state, advanced at each rising edge
  logic [3:0]  m_qr4;
  logic [7:0]  m_qr8;
  logic [15:0] m_qr16;
  logic [1:0]  m_sr;
  logic        m_chg4, m_chg8, m_chg16;
  logic        m_par4, m_par8, m_par16;

  mux4a1_bus_param #(.ANCHO(4)) dut4 (
    .clk(clk), .rst(rst), .S(s), .D0(d4[0]), .D1(d4[1]), .D2(d4[2]), .D3(d4[3]),
    .Q(q4), .Q_r(qr4), .S_r(sr4),
`ifdef MUX4A1_BUS_PARAM_PARITY_EN
    .CHG(chg4), .PAR(par4)
`else
    .CHG(chg4)
`endif
  );

  mux4a1_bus_param #(.ANCHO(8)) dut8 (
    .clk(clk), .rst(rst), .S(s), .D0(d8[0]), .D1(d8[1]), .D2(d8[2]), .D3(d8[3]),
    .Q(q8), .Q_r(qr8), .S_r(sr8),
`ifdef MUX4A1_BUS_PARAM_PARITY_EN
    .CHG(chg8), .PAR(par8)
`else
    .CHG(chg8)
`endif
  );

  mux4a1_bus_param #(.ANCHO(16)) dut16 (
    .clk(clk), .rst(rst), .S(s), .D0(d16[0]), .D1(d16[1]), .D2(d16[2]), .D3(d16[3]),
    .Q(q16), .Q_r(qr16), .S_r(sr16),
`ifdef MUX4A1_BUS_PARAM_PARITY_EN
    .CHG(chg16), .PAR(par16)
`else
    .CHG(chg16)
`endif
  );

`ifndef MUX4A1_BUS_PARAM_PARITY_EN
  assign par4  = 1'b0;
  assign par8  = 1'b0;
  assign par16 = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_qr4 <= '0; m_qr8 <= '0; m_qr16 <= '0; m_sr <= '0;
      m_chg4 <= 1'b0; m_chg8 <= 1'b0; m_chg16 <= 1'b0;
      m_par4 <= 1'b0; m_par8 <= 1'b0; m_par16 <= 1'b0;
    end else begin
      m_qr4  <= d4[s];
      m_qr8  <= d8[s];
      m_qr16 <= d16[s];
      m_sr   <= s;
      m_chg4  <= (d4[s]  != m_qr4);
      m_chg8  <= (d8[s]  != m_qr8);
      m_chg16 <= (d16[s] != m_qr16);
      m_par4  <= 1'($countones(d4[s])  % 2);
      m_par8  <= 1'($countones(d8[s])  % 2);
      m_par16 <= 1'($countones(d16[s]) % 2);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_comb();
    #1;
    check("q4",  32'(q4),  32'(d4[s]));
    check("q8",  32'(q8),  32'(d8[s]));
    check("q16", 32'(q16), 32'(d16[s]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("qr4",   32'(qr4),   32'(m_qr4));
    check("qr8",   32'(qr8),   32'(m_qr8));
    check("qr16",  32'(qr16),  32'(m_qr16));
    check("sr4",   32'(sr4),   32'(m_sr));
    check("sr8",   32'(sr8),   32'(m_sr));
    check("sr16",  32'(sr16),  32'(m_sr));
    check("chg4",  32'(chg4),  32'(m_chg4));
    check("chg8",  32'(chg8),  32'(m_chg8));
    check("chg16", 32'(chg16), 32'(m_chg16));
`ifdef MUX4A1_BUS_PARAM_PARITY_EN
    check("par4",  32'(par4),  32'(m_par4));
    check("par8",  32'(par8),  32'(m_par8));
    check("par16", 32'(par16), 32'(m_par16));
`endif
  endtask

  task automatic inc_all();
    for (int i = 0; i < 4; i++) begin
      d4[i]  = d4[i]  + 4'd1;
      d8[i]  = d8[i]  + 8'd1;
      d16[i] = d16[i] + 16'd1;
    end
  endtask

  initial begin
    rst = 1'b1;
    s   = 2'd0;
    d8[0] = 8'h28; d8[1] = 8'h11; d8[2] = 8'h22; d8[3] = 8'h33;
    for (int i = 0; i < 4; i++) begin
      d4[i]  = 4'(i + 3);
      d16[i] = 16'(16'h1000 * (i + 1));
    end

    // reset held for two edges; Q stays live
    tick();
    check("rst_qr8",  32'(qr8),  32'h0);
    check("rst_chg8", 32'(chg8), 32'h0);
    tick();
    check("rst_sr8",  32'(sr8), 32'h0);
    check("rst_q8",   32'(q8),  32'h28);
    rst = 1'b0;
    tick();
    check("rel_qr8",  32'(qr8),  32'h28);
    check("rel_chg8", 32'(chg8), 32'h1);
    tick();
    check("stable_chg8", 32'(chg8), 32'h0);

    // increment walk at 5 ns steps
    d8[0] = 8'd10; d8[1] = 8'd20; d8[2] = 8'd30; d8[3] = 8'd40;
    check_comb();
    check("tp10", 32'(q8), 32'd10);
    for (int k = 0; k < 3; k++) begin
      inc_all();
      #4;
      check_comb();
      check("tp_inc", 32'(q8), 32'(11 + k));
    end
    tick();
    s = 2'd1;
    check_comb();
    check("tp23", 32'(q8), 32'd23);
    for (int k = 0; k < 4; k++) begin
      s = 2'((k + 2) % 4);
      inc_all();
      check_comb();
      tick();
    end

    // 4-bit wrap on D3
    d4[0] = 4'd0; d4[1] = 4'd1; d4[2] = 4'd5; d4[3] = 4'd6;
    s = 2'd3;
    for (int k = 0; k < 12; k++) begin
      inc_all();
      check_comb();
      tick();
    end
    check("wrap_q4", 32'(q4), 32'd2);

    // changes on unselected inputs only
    s = 2'd2;
    tick();
    tick();
    d4[0] = ~d4[0]; d8[1] = ~d8[1]; d16[3] = ~d16[3];
    check_comb();
    tick();
    check("unsel_chg8", 32'(chg8), 32'h0);

`ifdef MUX4A1_BUS_PARAM_PARITY_EN
    d8[2] = 8'h07;
    tick();
    tick();
    check("par_07", 32'(par8), 32'h1);
    d8[2] = 8'h03;
    tick();
    tick();
    check("par_03", 32'(par8), 32'h0);
`endif

    // randomized traffic with occasional reset
    for (int k = 0; k < 300; k++) begin
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < 4; i++) begin
          d4[i]  = 4'($urandom);
          d8[i]  = 8'($urandom);
          d16[i] = 16'($urandom);
        end
      end
      rst = ($urandom_range(0, 15) == 0);
      check_comb();
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
